echo_delay: RTL



---
 rtl/echo_delay.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/echo_delay.sv
// ---------------------------------------------------------------------------
// echo_delay -- single-tap echo effect placed after the tremolo stage.
//
// Each accepted sample is mixed with an attenuated copy of the sample taken
// DEPTH samples earlier. That earlier sample is held in a circular delay
// buffer. The mixed sum is saturated to 16 bits and emitted with a
// one-cycle out_valid strobe, three cycles after sample_valid.
//
// Parameters:
//   DEPTH        delay length in samples (power of two, >= 2)
//   DECAY_SHIFT  arithmetic right shift applied to the delayed sample
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   en            effect enable; 0 = dry pass-through, pointer/fill cleared
//   sample_valid  one-cycle strobe qualifying audio_in
//   audio_in      signed 16-bit input sample
//   audio_out     signed 16-bit registered output sample
//   out_valid     one-cycle strobe, audio_out updated
//   busy          sample in flight; sample_valid ignored while high
//
// Build option:
//   ECHO_FEEDBACK_EN  when defined, the buffer stores the mixed output. This
//                     gives a regenerative echo train. When undefined, the
//                     buffer stores the dry input, so each sample echoes
//                     exactly once.
// ---------------------------------------------------------------------------
module echo_delay #(
  parameter int DEPTH       = 4096,
  parameter int DECAY_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sample_valid,
  input  logic signed [15:0] audio_in,
  output logic signed [15:0] audio_out,
  output logic               out_valid,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

  state_t               state_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [FW-1:0]        fill_q;
  logic signed [15:0]   audio_out_q;
  logic                 out_valid_q;
  logic                 busy_q;

  // Datapath registers and buffer storage (not reset)
  logic signed [15:0]   mem [DEPTH];
  logic signed [15:0]   ram_q;
  logic signed [15:0]   dry_q;
  logic signed [15:0]   del_q;

  logic                 accept;
  logic                 primed;
  logic                 wr_en;
  logic signed [15:0]   delayed_d;
  logic signed [16:0]   sum_d;
  logic signed [15:0]   mix_d;
  logic signed [15:0]   wdata_d;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s > 17'sd32767)
      sat16 = 16'sh7FFF;
    else if (s < -17'sd32768)
      sat16 = -16'sh8000;
    else
      sat16 = s[15:0];
  endfunction

  assign accept = (state_q == IDLE) && sample_valid && !busy_q;
  assign primed = (fill_q == FILL_MAX);
  assign wr_en  = (state_q == MIX) && en;

  always_comb begin
    delayed_d = '0;
    if (en && primed)
      delayed_d = del_q >>> DECAY_SHIFT;
    sum_d = {dry_q[15], dry_q} + {delayed_d[15], delayed_d};
    mix_d = sat16(sum_d);
`ifdef ECHO_FEEDBACK_EN
    wdata_d = mix_d;
`else
    wdata_d = dry_q;
`endif
  end

  // Buffer and data capture. The read happens on accept and the write
  // happens in MIX, so the single port is never used twice in one cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dry_q <= audio_in;
      ram_q <= mem[wr_ptr_q];
    end
    if (state_q == READ)
      del_q <= ram_q;
    if (wr_en)
      mem[wr_ptr_q] <= wdata_d;
  end

  // Control FSM with registered outputs. busy stays high through the
  // out_valid cycle as well, so that the strobe and the next accept never
  // overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          state_q <= MIX;
        end
        MIX: begin
          audio_out_q <= mix_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
          if (en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (!primed)
              fill_q <= fill_q + FW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Disabled: echo history is discarded, so the next enable starts unprimed
      if (!en) begin
        wr_ptr_q <= '0;
        fill_q   <= '0;
      end
    end
  end

  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
